rng_bit_collector: RTL
======================

# rng_bit_collector

Collects raw entropy bits from a TRNG cell over the BIT_READY/ACK handshake and von Neumann-debiases them. It runs a repetition-count health test on the raw stream and packs the debiased bits into a WIDTH-bit word, which it presents with a valid/ack handshake. It sits between a single TRNG entropy cell and the word consumer (display/register stage), so the consumer receives only full, debiased, health-checked words.

## Interface
- WIDTH, 16: output word width in bits (≥2).
- REP_LIMIT, 16: run of identical consecutive raw bits that trips the health test (≥2).
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- EN  input  1  collection enable; low aborts and clears any partial word.
- RAW_BIT  input  1  raw bit from TRNG; valid while RAW_READY high.
- RAW_READY  input  1  TRNG bit available (TRNG BIT_READY).
- RAW_ACK  output  1  one-cycle pulse consuming current raw bit (to TRNG ACK).
- WORD  output  WIDTH  collected word; stable while WORD_VALID high.
- WORD_VALID  output  1  WORD holds a complete word.
- WORD_ACK  input  1  consumer accepts WORD; sampled only while WORD_VALID high.
- HEALTH_FAIL  output  1  sticky repetition-test failure flag.

## Operation
- Reset values: RAW_ACK=0, WORD=0, WORD_VALID=0, HEALTH_FAIL=0; state IDLE; bit count, pair holder, run counter cleared.
- States: IDLE, COLLECT, WAIT_LOW, FULL, FAIL.
- IDLE: EN=1 → COLLECT. No acks issued.
- COLLECT: at an edge with RAW_READY=1, sample RAW_BIT, pulse RAW_ACK, go WAIT_LOW.
- WAIT_LOW: ignore RAW_BIT; first edge with RAW_READY=0 → COLLECT. This guarantees that one TRNG assertion is never consumed twice.
- Pairing: the first sampled bit of a pair is held. On the second bit, 01 yields debiased 0, 10 yields 1, and 00/11 are discarded. The holder clears after each second bit.
- Packing: debiased bit shifts in at LSB: WORD <= {WORD[WIDTH-2:0], b}. First bit produced ends up in MSB. The count increments per debiased bit.
- When the WIDTH-th debiased bit is accepted → FULL, WORD_VALID=1. No further RAW_ACK while FULL; TRNG is back-pressured.
- FULL: at an edge with WORD_ACK=1 → WORD_VALID=0, count=0, pair holder cleared, WORD keeps last value. Next state is COLLECT if EN=1, else IDLE.
- EN=0 in COLLECT/WAIT_LOW → IDLE; count, pair holder and run counter are cleared; WORD unchanged.
- EN=0 in FULL keeps the word presented until acked.
- Health test: run counter tracks consecutive identical raw bits (all sampled bits, both pair positions). It resets to 1 on a change and saturates at REP_LIMIT. On reaching REP_LIMIT → FAIL, HEALTH_FAIL=1.
- FAIL: WORD_VALID=0, no RAW_ACK, WORD_ACK ignored. Exit only by RST.
- WORD_ACK while WORD_VALID=0 is ignored.

## Timing
- RAW_ACK is registered. RAW_BIT is sampled at edge N, where RAW_READY=1 in COLLECT. RAW_ACK is high during cycle N+1 for exactly one cycle.
- The earliest next sample is at the first edge after the one that observes RAW_READY=0, giving a minimum of 3 cycles per raw bit.
- WORD_VALID rises in the cycle after the edge that samples the completing raw bit, with WORD already final.
- WORD_VALID falls in the cycle after the edge that observes WORD_ACK. Collection may resume on that same following edge.
- HEALTH_FAIL rises in the cycle after the edge that samples the REP_LIMIT-th identical bit. That bit is not packed, even if it would complete a word.
- If the health test trips and a word completes on the same edge, FAIL takes priority: WORD_VALID stays 0.
- RST mid-operation takes effect immediately (asynchronous): outputs go to reset values, including a RAW_ACK pulse cut short.

## Test plan
- WIDTH=4. Raw pairs 01,10,01,10, each with a proper handshake → WORD=4'b0101, WORD_VALID=1 one cycle after the 8th sample, exactly 8 RAW_ACK pulses.
- WIDTH=4. Raw 00,11,01,11,10,01,10 → discarded pairs produce no bits; WORD=4'b0101 after the 14th sample.
- RAW_READY held high for 10 cycles after one sample → exactly one RAW_ACK and one bit consumed until RAW_READY drops.
- Word full, WORD_ACK withheld 20 cycles with RAW_READY=1 → no RAW_ACK, WORD stable. After WORD_ACK, WORD_VALID drops next cycle and collection resumes.
- REP_LIMIT=16. 16 consecutive raw 1s → HEALTH_FAIL=1 after the 16th sample; no further acks or words. RST clears it.
- EN dropped after 3 debiased bits, then re-raised → new word contains only post-re-enable bits. Async RST pulse mid-word → all outputs 0 immediately.

Source files
------------

// File: rtl/rng_bit_collector_if.sv
// Handshake bundle between the TRNG cell, the bit collector and the word consumer.
// The slave side is the collector; the master side drives enable, raw bits and word acks.
interface rng_bit_collector_if #(
  parameter int unsigned WIDTH = 16
);
  logic             en;
  logic             raw_bit;
  logic             raw_ready;
  logic             raw_ack;
  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             word_ack;
  logic             health_fail;

  modport slave (
    input  en, raw_bit, raw_ready, word_ack,
    output raw_ack, word, word_valid, health_fail
  );

  modport master (
    output en, raw_bit, raw_ready, word_ack,
    input  raw_ack, word, word_valid, health_fail
  );
endinterface

// File: rtl/rng_bit_collector.sv
// Pulls raw TRNG bits over a ready/ack handshake, von Neumann-debiases them, packs WIDTH-bit
// words and runs a repetition-count health test that latches a permanent failure.
module rng_bit_collector #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned REP_LIMIT = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rng_bit_collector_if.slave  bus_io
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned RunW = $clog2(REP_LIMIT + 1);

  typedef enum logic [2:0] {StIdle, StCollect, StWaitLow, StFull, StFail} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             hold_vld_q, hold_vld_d;
  logic             hold_q, hold_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             last_q, last_d;
  logic             raw_ack_q, raw_ack_d;
  logic [RunW-1:0]  run_next;

  // Length of the identical-bit run including the bit on raw_bit, saturating at REP_LIMIT.
  always_comb begin
    run_next = RunW'(1);
    if (run_q != '0 && bus_io.raw_bit == last_q) begin
      run_next = (run_q == RunW'(REP_LIMIT)) ? run_q : run_q + RunW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    run_d      = run_q;
    last_d     = last_q;
    raw_ack_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.en) state_d = StCollect;
      end
      StCollect, StWaitLow: begin
        if (!bus_io.en) begin
          state_d    = StIdle;
          cnt_d      = '0;
          hold_vld_d = 1'b0;
          run_d      = '0;
        end else if (state_q == StWaitLow) begin
          if (!bus_io.raw_ready) state_d = StCollect;
        end else if (bus_io.raw_ready) begin
          raw_ack_d = 1'b1;
          last_d    = bus_io.raw_bit;
          run_d     = run_next;
          state_d   = StWaitLow;
          // A tripping bit is consumed but never packed.
          if (run_next == RunW'(REP_LIMIT)) begin
            state_d = StFail;
          end else if (!hold_vld_q) begin
            hold_vld_d = 1'b1;
            hold_d     = bus_io.raw_bit;
          end else begin
            hold_vld_d = 1'b0;
            if (hold_q != bus_io.raw_bit) begin
              word_d = {word_q[WIDTH-2:0], hold_q};
              cnt_d  = cnt_q + CntW'(1);
              if (cnt_q == CntW'(WIDTH - 1)) state_d = StFull;
            end
          end
        end
      end
      StFull: begin
        if (bus_io.word_ack) begin
          cnt_d      = '0;
          hold_vld_d = 1'b0;
          state_d    = bus_io.en ? StCollect : StIdle;
        end
      end
      StFail: begin
        state_d = StFail;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      word_q     <= '0;
      cnt_q      <= '0;
      hold_vld_q <= 1'b0;
      hold_q     <= 1'b0;
      run_q      <= '0;
      last_q     <= 1'b0;
      raw_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      run_q      <= run_d;
      last_q     <= last_d;
      raw_ack_q  <= raw_ack_d;
    end
  end

  assign bus_io.raw_ack     = raw_ack_q;
  assign bus_io.word        = word_q;
  assign bus_io.word_valid  = (state_q == StFull);
  assign bus_io.health_fail = (state_q == StFail);
endmodule
